// File: rtl/trace_logger.sv
// trace_logger: stages trace words and writes them into a circular buffer in capture or stream mode
module trace_logger #(
    parameter int TRB_WIDTH      = 32,
    parameter int TRB_DEPTH      = 64,
    parameter int TRB_ADDR_WIDTH = $clog2(TRB_DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      enable_i,
    input  logic                      mode_i,
    input  logic [TRB_ADDR_WIDTH-1:0] trg_delay_i,
    input  logic [TRB_WIDTH-1:0]      trace_i,
    input  logic                      trace_valid_i,
    input  logic                      trg_i,
    output logic                      trace_ready_o,
    input  logic                      rw_turn_i,
    input  logic                      write_allow_i,
    input  logic                      read_allow_i,
    output logic [TRB_ADDR_WIDTH-1:0] read_ptr_o,
    output logic [TRB_ADDR_WIDTH-1:0] write_ptr_o,
    output logic                      write_o,
    output logic [TRB_WIDTH-1:0]      data_o,
    output logic                      trg_event_o,
    output logic                      done_o
);
    typedef enum logic [1:0] {IDLE, RUN, POST, DONE} state_e;
    state_e                    state_q, state_d;
    logic                      mode_q, mode_d;
    logic [TRB_ADDR_WIDTH-1:0] wr_q, wr_d, rd_q, rd_d, cnt_q, cnt_d;
    logic [TRB_WIDTH-1:0]      hold_q, hold_d;
    logic                      hold_trg_q, hold_trg_d, hold_vld_q, hold_vld_d;
    logic                      trg_ev_q, trg_ev_d;
    logic                      active, full, empty, accept, rd_adv;

    assign active        = (state_q == RUN) || (state_q == POST);
    assign empty         = wr_q == rd_q;
    assign full          = (wr_q + 1'b1) == rd_q;
    assign write_o       = hold_vld_q & ~rw_turn_i & write_allow_i & active & (~mode_q | ~full);
    assign trace_ready_o = active & (~hold_vld_q | write_o);
    assign accept        = trace_valid_i & trace_ready_o;
    assign rd_adv        = mode_q & ~rw_turn_i & read_allow_i & ~empty & active;
    assign data_o        = hold_q;
    assign write_ptr_o   = wr_q;
    assign read_ptr_o    = rd_q;
    assign done_o        = state_q == DONE;
    assign trg_event_o   = trg_ev_q | done_o;

    // next-state: pointer movement, hold staging, trigger/post-delay sequencing
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        hold_trg_d = hold_trg_q;
        hold_vld_d = hold_vld_q;
        trg_ev_d   = 1'b0;
        if (state_q == IDLE) begin
            if (enable_i) begin
                state_d    = RUN;
                mode_d     = mode_i;
                wr_d       = '0;
                rd_d       = '0;
                hold_vld_d = 1'b0;
            end
        end else begin
            wr_d       = write_o ? wr_q + 1'b1 : wr_q;
            rd_d       = ((write_o & ~mode_q & full) | rd_adv) ? rd_q + 1'b1 : rd_q;
            hold_d     = accept ? trace_i : hold_q;
            hold_trg_d = accept ? trg_i : hold_trg_q;
            hold_vld_d = accept | (hold_vld_q & ~write_o);
            if (write_o && hold_trg_q && state_q == RUN) begin
                if (mode_q) begin
                    trg_ev_d = 1'b1;
                end else begin
                    cnt_d   = trg_delay_i;
                    state_d = (trg_delay_i == '0) ? DONE : POST;
                end
            end
            if (write_o && state_q == POST) begin
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == TRB_ADDR_WIDTH'(1)) ? DONE : POST;
            end
            if (!enable_i) begin
                state_d    = IDLE;
                hold_vld_d = 1'b0;
            end
        end
    end

    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            hold_q     <= '0;
            hold_trg_q <= 1'b0;
            hold_vld_q <= 1'b0;
            trg_ev_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            hold_q     <= hold_d;
            hold_trg_q <= hold_trg_d;
            hold_vld_q <= hold_vld_d;
            trg_ev_q   <= trg_ev_d;
        end
    end
endmodule

// File: tb/tb_trace_logger.sv
// tb_trace_logger: scoreboard bench for trace_logger covering capture, stream, trigger, enable drop and reset
module tb_trace_logger;
    localparam int W = 32;
    localparam int A = 6;

    logic         clk_i = 1'b0, rst_ni = 1'b0, enable_i = 1'b0, mode_i = 1'b0;
    logic [A-1:0] trg_delay_i = '0;
    logic [W-1:0] trace_i = '0;
    logic         trace_valid_i = 1'b0, trg_i = 1'b0, rw_turn_i = 1'b0;
    logic         write_allow_i = 1'b0, read_allow_i = 1'b0;
    logic         trace_ready_o, write_o, trg_event_o, done_o;
    logic [A-1:0] read_ptr_o, write_ptr_o;
    logic [W-1:0] data_o;

    trace_logger dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .mode_i(mode_i),
        .trg_delay_i(trg_delay_i), .trace_i(trace_i), .trace_valid_i(trace_valid_i),
        .trg_i(trg_i), .trace_ready_o(trace_ready_o), .rw_turn_i(rw_turn_i),
        .write_allow_i(write_allow_i), .read_allow_i(read_allow_i),
        .read_ptr_o(read_ptr_o), .write_ptr_o(write_ptr_o), .write_o(write_o),
        .data_o(data_o), .trg_event_o(trg_event_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    int errs = 0, checks = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] word(input int i);
        return W'(i) * 32'h9E3779B1 + 32'h1234;
    endfunction

    // reference model state, owned by the monitor
    int           m_state = 0;
    bit           m_mode = 0, m_ev = 0;
    logic [A-1:0] m_wr = '0, m_rd = '0, m_cnt = '0;
    logic [W:0]   q[$];
    int           next_word = 0, nwr = 0;

    // stimulus knobs, owned by the main sequence
    bit rnd = 0;
    int n_words = 0, trg_at = -1, ra_at = -1, cyc = 0;

    // input driver, just after each rising edge
    always @(posedge clk_i) begin
        #1;
        cyc++;
        trace_i       = word(next_word);
        trg_i         = (next_word == trg_at);
        trace_valid_i = (next_word < n_words) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
        rw_turn_i     = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        write_allow_i = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        read_allow_i  = rnd ? 1'($urandom_range(0, 1)) : (cyc == ra_at);
    end

    // monitor/scoreboard on the falling edge: check, then advance the model to the next rising edge
    always @(negedge clk_i) begin
        bit           act, full, empty, ew, er, acc, rdy, trg, dfull;
        logic [A-1:0] nx;
        if (!rst_ni) begin
            chk("rst_wptr", write_ptr_o, 0);
            chk("rst_rptr", read_ptr_o, 0);
            chk("rst_write", write_o, 0);
            chk("rst_ready", trace_ready_o, 0);
            chk("rst_done", done_o, 0);
            chk("rst_trgev", trg_event_o, 0);
            chk("rst_data", data_o, 0);
            m_state = 0; m_wr = '0; m_rd = '0; m_ev = 0; m_mode = 0;
            q.delete();
        end else begin
            chk("wptr", write_ptr_o, m_wr);
            chk("rptr", read_ptr_o, m_rd);
            chk("done", done_o, m_state == 3);
            chk("trgev", trg_event_o, m_ev | (m_state == 3));
            act   = (m_state == 1) || (m_state == 2);
            nx    = m_wr + 1;
            full  = nx == m_rd;
            empty = m_wr == m_rd;
            ew    = (q.size() > 0) && !rw_turn_i && write_allow_i && act && (!m_mode || !full);
            rdy   = act && ((q.size() == 0) || ew);
            chk("write", write_o, ew);
            chk("ready", trace_ready_o, rdy);
            if (write_o && m_mode) begin
                nx    = write_ptr_o + 1;
                dfull = nx == read_ptr_o;
                chk("stream_wr_full", dfull, 0);
            end
            if (m_state == 0) begin
                m_ev = 0;
                if (enable_i) begin
                    m_state = 1; m_wr = '0; m_rd = '0; m_mode = mode_i;
                    q.delete(); next_word = 0; nwr = 0;
                end
            end else begin
                er   = m_mode && !rw_turn_i && read_allow_i && !empty && act;
                acc  = trace_valid_i && rdy;
                m_ev = 0;
                if (ew) begin
                    chk("data", data_o, q[0][W-1:0]);
                    trg = q[0][W];
                    void'(q.pop_front());
                    nwr++;
                    if (!m_mode && full) m_rd++;
                    m_wr++;
                    if (m_state == 1 && trg) begin
                        if (m_mode) m_ev = 1;
                        else begin
                            m_cnt   = trg_delay_i;
                            m_state = (trg_delay_i == 0) ? 3 : 2;
                        end
                    end else if (m_state == 2) begin
                        m_cnt--;
                        if (m_cnt == 0) m_state = 3;
                    end
                end
                if (er) m_rd++;
                if (acc) begin
                    q.push_back({trg_i, trace_i});
                    next_word++;
                end
                if (!enable_i) begin
                    m_state = 0;
                    q.delete();
                end
            end
        end
    end

    task automatic start(input bit md, input int nw, input int ta, input logic [A-1:0] dly);
        @(posedge clk_i); #2;
        mode_i = md; n_words = nw; trg_at = ta; trg_delay_i = dly; enable_i = 1'b1;
    endtask

    task automatic stop();
        @(posedge clk_i); #2;
        enable_i = 1'b0; n_words = 0; rnd = 0;
        repeat (2) @(posedge clk_i);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400 && !done_o; i++) @(negedge clk_i);
        chk("reach_done", done_o, 1);
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #2 rst_ni = 1'b1;

        // capture, no trigger, 100 words
        start(0, 100, -1, 0);
        for (int i = 0; i < 400 && !(next_word == 100 && q.size() == 0); i++) @(posedge clk_i);
        @(negedge clk_i); #1;
        chk("cap_wptr", write_ptr_o, 36);
        chk("cap_rptr", read_ptr_o, 37);
        chk("cap_done", done_o, 0);
        chk("cap_nwr", nwr, 100);
        stop();

        // capture, trigger on word 10, delay 5
        start(0, 100, 10, 5);
        wait_done();
        repeat (3) @(negedge clk_i); #1;
        chk("t5_wptr", write_ptr_o, 16);
        chk("t5_trgev", trg_event_o, 1);
        chk("t5_ready", trace_ready_o, 0);
        chk("t5_nwr", nwr, 16);
        stop();

        // capture, trigger on word 0, delay 0
        start(0, 100, 0, 0);
        wait_done();
        repeat (2) @(negedge clk_i); #1;
        chk("t0_wptr", write_ptr_o, 1);
        chk("t0_nwr", nwr, 1);
        stop();

        // stream until full, then a single read grant
        start(1, 70, -1, 0);
        repeat (120) @(posedge clk_i);
        @(negedge clk_i); #1;
        chk("sf_wptr", write_ptr_o, 63);
        chk("sf_rptr", read_ptr_o, 0);
        chk("sf_ready", trace_ready_o, 0);
        chk("sf_nwr", nwr, 63);
        @(posedge clk_i); #2;
        ra_at = cyc + 1;
        repeat (4) @(negedge clk_i); #1;
        chk("sf_rptr1", read_ptr_o, 1);
        chk("sf_wrap", write_ptr_o, 0);
        chk("sf_nwr1", nwr, 64);
        stop();

        // random stream traffic
        rnd = 1;
        start(1, 1000000, 50, 0);
        repeat (1000) @(posedge clk_i);
        stop();

        // enable drop mid-RUN, then re-enable
        start(0, 100, -1, 0);
        repeat (20) @(posedge clk_i);
        #2 enable_i = 1'b0;
        repeat (2) @(negedge clk_i); #1;
        chk("drop_ready", trace_ready_o, 0);
        chk("drop_write", write_o, 0);
        @(posedge clk_i); #2 enable_i = 1'b1;
        repeat (2) @(negedge clk_i); #1;
        chk("reen_wptr", write_ptr_o, 0);
        chk("reen_rptr", read_ptr_o, 0);
        stop();

        // asynchronous reset mid-POST
        start(0, 100, 5, 40);
        for (int i = 0; i < 100 && nwr < 15; i++) @(posedge clk_i);
        chk("in_post_done", done_o, 0);
        @(posedge clk_i); #3 rst_ni = 1'b0;
        #1;
        chk("arst_wptr", write_ptr_o, 0);
        chk("arst_rptr", read_ptr_o, 0);
        chk("arst_write", write_o, 0);
        chk("arst_ready", trace_ready_o, 0);
        chk("arst_data", data_o, 0);
        @(posedge clk_i); #2 rst_ni = 1'b1;
        repeat (5) @(posedge clk_i);
        stop();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
